// File: rtl/huffman_queue_ctrl.sv
// Huffman priority-queue sequencer: sorted leaf insertion, then pop-two/insert-one
// merge loop until a single root remains. Sole writer of the external 6-slot queue.
module huffman_queue_ctrl #(
    parameter int DEPTH  = 6,
    parameter int FREQ_W = 32
) (
    input  logic                    clk,
    input  logic                    ctrl_reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_ascii,
    input  logic [FREQ_W-1:0]       in_freq,
    input  logic                    in_last,
    input  logic                    clear,
    input  logic [DEPTH*FREQ_W-1:0] q_rd_freq,
    input  logic [8*DEPTH-1:0]      q_rd_ascii,
    input  logic [DEPTH-1:0]        q_rd_head,
    output logic [DEPTH-1:0]        q_wr_en,
    output logic [8*DEPTH-1:0]      q_wr_pos,
    output logic [8*DEPTH-1:0]      q_wr_ascii,
    output logic [DEPTH*FREQ_W-1:0] q_wr_freq,
    output logic [DEPTH-1:0]        q_wr_head,
    output logic                    merge_valid,
    input  logic                    merge_ready,
    output logic [8:0]              merge_left_id,
    output logic [8:0]              merge_right_id,
    output logic [8:0]              merge_node_id,
    output logic [FREQ_W-1:0]       merge_freq,
    output logic                    done,
    output logic [8:0]              root_id,
    output logic [FREQ_W-1:0]       root_freq
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_LOAD, S_MERGE, S_DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   count, count_nx;
    logic [CW-1:0]   k, k_nx;
    logic            accept, fire;
    logic [CW-1:0]   p_load, p_merge;
    logic [FREQ_W:0] sum_full;
    logic [FREQ_W-1:0] sat_freq;

    // Slot i lives at ext[i+1]; zero pads at both ends keep j-1 / j+2 reads in range.
    logic [FREQ_W-1:0] ext_freq [DEPTH+3];
    logic [8:0]        ext_id   [DEPTH+3];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH + 3; i++) begin
            ext_freq[i] = '0;
            ext_id[i]   = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ext_freq[i+1] = q_rd_freq[FREQ_W*i +: FREQ_W];
            ext_id[i+1]   = {q_rd_head[i], q_rd_ascii[8*i +: 8]};
        end
    end

    assign accept   = (state == S_LOAD) && (count < CW'(DEPTH)) && !ctrl_reset && in_valid;
    assign fire     = (state == S_MERGE) && merge_ready;
    assign sum_full = {1'b0, ext_freq[1]} + {1'b0, ext_freq[2]};
    assign sat_freq = sum_full[FREQ_W] ? '1 : sum_full[FREQ_W-1:0];

    always_comb begin
        p_load  = '0;
        p_merge = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && ext_freq[i+1] <= in_freq)
                p_load = p_load + CW'(1);
            if (i >= 2 && CW'(i) < count && ext_freq[i+1] <= sat_freq)
                p_merge = p_merge + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state <= S_LOAD;
            count <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            k     <= k_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        k_nx     = k;
        case (state)
            S_LOAD: begin
                if (accept) begin
                    count_nx = count + CW'(1);
                    if (in_last || count_nx == CW'(DEPTH))
                        state_nx = (count_nx >= CW'(2)) ? S_MERGE : S_DONE;
                end
            end
            S_MERGE: begin
                if (fire) begin
                    count_nx = count - CW'(1);
                    k_nx     = k + CW'(1);
                    if (count_nx == CW'(1))
                        state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_nx = S_LOAD;
                    count_nx = '0;
                    k_nx     = '0;
                end
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready       = (state == S_LOAD) && (count < CW'(DEPTH)) && !ctrl_reset;
        q_wr_en        = '0;
        q_wr_ascii     = '0;
        q_wr_freq      = '0;
        q_wr_head      = '0;
        merge_valid    = 1'b0;
        merge_left_id  = '0;
        merge_right_id = '0;
        merge_node_id  = '0;
        merge_freq     = '0;
        done           = 1'b0;
        root_id        = '0;
        root_freq      = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            q_wr_pos[8*j +: 8] = 8'(j);
            if (accept) begin
                if (CW'(j) == p_load) begin
                    q_wr_en[j]                   = 1'b1;
                    q_wr_freq[FREQ_W*j +: FREQ_W] = in_freq;
                    q_wr_ascii[8*j +: 8]         = in_ascii;
                end else if (CW'(j) > p_load && CW'(j) <= count) begin
                    q_wr_en[j]                   = 1'b1;
                    q_wr_freq[FREQ_W*j +: FREQ_W] = ext_freq[j];
                    {q_wr_head[j], q_wr_ascii[8*j +: 8]} = ext_id[j];
                end
            end else if (fire && CW'(j) < count - CW'(1)) begin
                q_wr_en[j] = 1'b1;
                if (CW'(j) < p_merge) begin
                    q_wr_freq[FREQ_W*j +: FREQ_W] = ext_freq[j+3];
                    {q_wr_head[j], q_wr_ascii[8*j +: 8]} = ext_id[j+3];
                end else if (CW'(j) == p_merge) begin
                    q_wr_freq[FREQ_W*j +: FREQ_W] = sat_freq;
                    q_wr_ascii[8*j +: 8]         = 8'(k);
                    q_wr_head[j]                 = 1'b1;
                end else begin
                    q_wr_freq[FREQ_W*j +: FREQ_W] = ext_freq[j+2];
                    {q_wr_head[j], q_wr_ascii[8*j +: 8]} = ext_id[j+2];
                end
            end
        end
        if (state == S_MERGE) begin
            merge_valid    = 1'b1;
            merge_left_id  = ext_id[1];
            merge_right_id = ext_id[2];
            merge_node_id  = {1'b1, 8'(k)};
            merge_freq     = sat_freq;
        end
        if (state == S_DONE) begin
            done      = 1'b1;
            root_id   = ext_id[1];
            root_freq = ext_freq[1];
        end
    end
endmodule

// File: tb/tb_huffman_queue_ctrl.sv
// Bench for huffman_queue_ctrl: behavioural slot array, sorted-list reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_huffman_queue_ctrl;
    localparam int DEPTH  = 6;
    localparam int FREQ_W = 32;

    logic                    clk = 1'b0;
    logic                    ctrl_reset;
    logic                    in_valid, in_ready, in_last, clear;
    logic [7:0]              in_ascii;
    logic [FREQ_W-1:0]       in_freq;
    logic [DEPTH*FREQ_W-1:0] q_rd_freq, q_wr_freq;
    logic [8*DEPTH-1:0]      q_rd_ascii, q_wr_ascii, q_wr_pos;
    logic [DEPTH-1:0]        q_rd_head, q_wr_head, q_wr_en;
    logic                    merge_valid, merge_ready, done;
    logic [8:0]              merge_left_id, merge_right_id, merge_node_id, root_id;
    logic [FREQ_W-1:0]       merge_freq, root_freq;

    int checks = 0;
    int errors = 0;

    huffman_queue_ctrl #(.DEPTH(DEPTH), .FREQ_W(FREQ_W)) dut (
        .clk(clk), .ctrl_reset(ctrl_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ascii(in_ascii),
        .in_freq(in_freq), .in_last(in_last), .clear(clear),
        .q_rd_freq(q_rd_freq), .q_rd_ascii(q_rd_ascii), .q_rd_head(q_rd_head),
        .q_wr_en(q_wr_en), .q_wr_pos(q_wr_pos), .q_wr_ascii(q_wr_ascii),
        .q_wr_freq(q_wr_freq), .q_wr_head(q_wr_head),
        .merge_valid(merge_valid), .merge_ready(merge_ready),
        .merge_left_id(merge_left_id), .merge_right_id(merge_right_id),
        .merge_node_id(merge_node_id), .merge_freq(merge_freq),
        .done(done), .root_id(root_id), .root_freq(root_freq)
    );

    always #5 clk = ~clk;

    // External queue: each slot captures its own write lanes.
    logic [FREQ_W-1:0] s_freq [DEPTH];
    logic [7:0]        s_ascii[DEPTH];
    logic              s_head [DEPTH];

    always_ff @(posedge clk or posedge ctrl_reset) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ctrl_reset) begin
                s_freq[i] <= '0; s_ascii[i] <= '0; s_head[i] <= 1'b0;
            end else if (q_wr_en[i]) begin
                s_freq[i]  <= q_wr_freq[FREQ_W*i +: FREQ_W];
                s_ascii[i] <= q_wr_ascii[8*i +: 8];
                s_head[i]  <= q_wr_head[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_rd_freq[FREQ_W*i +: FREQ_W] = s_freq[i];
            q_rd_ascii[8*i +: 8]         = s_ascii[i];
            q_rd_head[i]                 = s_head[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 loading, 1 merging, 2 finished.
    logic [FREQ_W-1:0] mfreq[$];
    logic [8:0]        mid[$];
    int                mphase = 0;
    int                mk = 0;

    function automatic int first_greater(input logic [FREQ_W-1:0] f);
        int idx = 0;
        while (idx < mfreq.size() && mfreq[idx] <= f) idx++;
        return idx;
    endfunction

    always @(negedge clk) begin
        logic        e_ready, e_mv, e_done;
        logic [8:0]  e_l, e_r, e_n, e_root;
        logic [63:0] e_f, e_rf;
        logic [DEPTH-1:0] e_en;
        int pos, sz;
        if (ctrl_reset) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_wr_en", q_wr_en, 0);
            chk("rst_merge_valid", merge_valid, 0);
            chk("rst_done", done, 0);
            mfreq.delete(); mid.delete(); mphase = 0; mk = 0;
        end else begin
            sz = mfreq.size();
            e_ready = (mphase == 0) && (sz < DEPTH);
            e_mv = (mphase == 1);
            e_done = (mphase == 2);
            e_l = 0; e_r = 0; e_n = 0; e_f = 0; e_root = 0; e_rf = 0; e_en = 0;
            if (e_mv) begin
                e_l = mid[0]; e_r = mid[1]; e_n = 9'h100 + 9'(mk);
                e_f = 64'(mfreq[0]) + 64'(mfreq[1]);
                if (e_f > 64'hFFFF_FFFF) e_f = 64'hFFFF_FFFF;
            end
            if (e_done) begin e_root = mid[0]; e_rf = 64'(mfreq[0]); end
            chk("in_ready", in_ready, e_ready);
            chk("merge_valid", merge_valid, e_mv);
            chk("merge_left", merge_left_id, e_l);
            chk("merge_right", merge_right_id, e_r);
            chk("merge_node", merge_node_id, e_n);
            chk("merge_freq", merge_freq, e_f);
            chk("done", done, e_done);
            chk("root_id", root_id, e_root);
            chk("root_freq", root_freq, e_rf);
            if (e_ready && in_valid) begin
                pos = first_greater(in_freq);
                for (int j = pos; j <= sz; j++) e_en[j] = 1'b1;
                mfreq.insert(pos, in_freq);
                mid.insert(pos, {1'b0, in_ascii});
                if (in_last || mfreq.size() == DEPTH)
                    mphase = (mfreq.size() >= 2) ? 1 : 2;
            end else if (e_mv && merge_ready) begin
                for (int j = 0; j < sz - 1; j++) e_en[j] = 1'b1;
                void'(mfreq.pop_front()); void'(mfreq.pop_front());
                void'(mid.pop_front());   void'(mid.pop_front());
                pos = first_greater(e_f[FREQ_W-1:0]);
                mfreq.insert(pos, e_f[FREQ_W-1:0]);
                mid.insert(pos, e_n);
                mk++;
                if (mfreq.size() == 1) mphase = 2;
            end else if (e_done && clear) begin
                mfreq.delete(); mid.delete(); mphase = 0; mk = 0;
            end
            chk("wr_en", q_wr_en, e_en);
        end
    end

    task automatic send(input logic [7:0] a, input logic [FREQ_W-1:0] f, input logic last);
        bit ok = 0;
        in_valid = 1; in_ascii = a; in_freq = f; in_last = last;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (merge_valid) ok = 1;
        end
        if (!ok) chk("merge_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic fire_merge();
        @(posedge clk); #1 merge_ready = 1;
        @(posedge clk); #1 merge_ready = 0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear = 1;
        @(posedge clk); #1 clear = 0;
    endtask

    task automatic lit_merge(input string nm, input logic [8:0] l, input logic [8:0] r,
                             input logic [FREQ_W-1:0] f, input logic [8:0] n);
        chk({nm, "_left"}, merge_left_id, l);
        chk({nm, "_right"}, merge_right_id, r);
        chk({nm, "_freq"}, merge_freq, f);
        chk({nm, "_node"}, merge_node_id, n);
    endtask

    logic [8:0]        t_l[5] = '{9'h061, 9'h063, 9'h064, 9'h066, 9'h102};
    logic [8:0]        t_r[5] = '{9'h062, 9'h100, 9'h065, 9'h101, 9'h103};
    logic [FREQ_W-1:0] t_f[5] = '{3, 6, 9, 12, 21};

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        ctrl_reset = 1; in_valid = 0; in_ascii = 0; in_freq = 0; in_last = 0;
        clear = 0; merge_ready = 0;
        repeat (3) @(posedge clk);
        #1 ctrl_reset = 0;
        @(negedge clk);
        chk("post_reset_ready", in_ready, 1);
        @(posedge clk); #1;

        // A:5 B:1 C:3 -> slots B,C,A
        send(8'h41, 5, 0); send(8'h42, 1, 0); send(8'h43, 3, 1);
        wait_valid();
        chk("slot0", q_rd_ascii[7:0], 8'h42);
        chk("slot1", q_rd_ascii[15:8], 8'h43);
        chk("slot2", q_rd_ascii[23:16], 8'h41);
        lit_merge("abc_m0", 9'h042, 9'h043, 4, 9'h100);
        fire_merge();
        wait_valid();
        lit_merge("abc_m1", 9'h100, 9'h041, 9, 9'h101);
        fire_merge();
        wait_done();
        chk("abc_root_id", root_id, 9'h101);
        chk("abc_root_freq", root_freq, 9);
        do_clear();

        // Ties: X:2 Y:2 Z:4; merged 4 lands after Z
        send(8'h58, 2, 0); send(8'h59, 2, 0); send(8'h5A, 4, 1);
        wait_valid();
        lit_merge("tie_m0", 9'h058, 9'h059, 4, 9'h100);
        fire_merge();
        wait_valid();
        lit_merge("tie_m1", 9'h05A, 9'h100, 8, 9'h101);
        fire_merge();
        wait_done();
        chk("tie_root_id", root_id, 9'h101);
        do_clear();

        // Six leaves fill the queue; back-to-back merges with a 3-cycle stall
        for (int i = 0; i < 6; i++) send(8'(8'h61 + i), FREQ_W'(i + 1), 0);
        merge_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("full_in_ready", in_ready, 0);
            chk("six_valid", merge_valid, 1);
            lit_merge("six", t_l[i], t_r[i], t_f[i], 9'h100 + 9'(i));
            if (i == 1) begin @(posedge clk); #1 merge_ready = 0; end
            if (i == 2) begin
                chk("stall_wr_en", q_wr_en, 0);
                repeat (2) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("stall_wr_en", q_wr_en, 0);
                    lit_merge("stall", t_l[2], t_r[2], t_f[2], 9'h102);
                end
                @(posedge clk); #1 merge_ready = 1;
                @(negedge clk);
            end
        end
        @(negedge clk);
        chk("six_done", done, 1);
        chk("six_root_id", root_id, 9'h104);
        chk("six_root_freq", root_freq, 21);
        @(posedge clk); #1 merge_ready = 0;
        do_clear();

        // Saturating sum
        send(8'h53, 32'hFFFF_FFF0, 0); send(8'h54, 32'h20, 1);
        wait_valid();
        lit_merge("sat", 9'h054, 9'h053, 32'hFFFF_FFFF, 9'h100);
        fire_merge();
        wait_done();
        chk("sat_root_freq", root_freq, 32'hFFFF_FFFF);
        do_clear();

        // Single leaf goes straight to done
        send(8'h51, 7, 1);
        @(negedge clk);
        chk("single_valid", merge_valid, 0);
        chk("single_done", done, 1);
        chk("single_root_id", root_id, 9'h051);
        chk("single_root_freq", root_freq, 7);
        do_clear();
        @(negedge clk);
        chk("clear_ready", in_ready, 1);
        chk("clear_done", done, 0);
        @(posedge clk); #1;

        // Reset while a merge is pending
        send(8'h4D, 3, 0); send(8'h4E, 4, 1);
        wait_valid();
        @(posedge clk); #1 ctrl_reset = 1;
        @(negedge clk);
        chk("midrst_valid", merge_valid, 0);
        @(posedge clk); #1 ctrl_reset = 0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_merge", merge_valid, 0);
            chk("midrst_ready", in_ready, 1);
        end
        @(posedge clk); #1;
        send(8'h55, 9, 0); send(8'h56, 8, 1);
        wait_valid();
        lit_merge("after_rst", 9'h056, 9'h055, 17, 9'h100);
        fire_merge();
        wait_done();
        chk("after_rst_root", root_id, 9'h100);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/huffman_queue_ctrl.md
# huffman_queue_ctrl

Sequencer for the 6-slot Huffman priority queue. It accepts (symbol, frequency) leaves from the histogram stage and keeps the queue sorted in ascending frequency order using parallel per-slot writes. It then runs the Huffman merge loop: pop the two minima, emit a merge event, and insert the internal node, until one root remains. It sits between the frequency counter and the tree/codebook builder, and it is the only writer of the queue slots.

## Interface
Parameters:
- DEPTH, 6, queue slots (fixed; queue instance is 6 slots)
- FREQ_W, 32, frequency width

Ports:
- clk  in  1  system clock
- ctrl_reset  in  1  asynchronous, active-high reset (also drives queue slot reset)
- in_valid  in  1  leaf offered
- in_ready  out  1  leaf accepted when in_valid && in_ready
- in_ascii  in  8  leaf symbol
- in_freq  in  FREQ_W  leaf frequency
- in_last  in  1  final leaf of this block
- clear  in  1  one-cycle pulse; DONE -> LOAD, count := 0
- q_rd_freq  in  6*FREQ_W  slot i at [FREQ_W*i +: FREQ_W]
- q_rd_ascii  in  48  slot node-id[7:0]
- q_rd_head  in  6  slot node-id[8] (internal flag)
- q_wr_en  out  6  per slot; drives all four slot write controls
- q_wr_pos  out  48  slot index written (= i)
- q_wr_ascii  out  48
- q_wr_freq  out  6*FREQ_W
- q_wr_head  out  6
- merge_valid  out  1  merge event pending
- merge_ready  in  1  consumer accepts
- merge_left_id, merge_right_id  out  9  {internal, id}
- merge_node_id  out  9  new internal node id
- merge_freq  out  FREQ_W  merged frequency
- done  out  1  tree complete
- root_id  out  9
- root_freq  out  FREQ_W

## Operation
- Node ids: leaf = {0, ascii}; internal = {1, k} with k = merge index 0..4. In a slot: ascii field = id[7:0], head = id[8].
- The controller tracks occupancy as count (0..6). Slots 0..count-1 are valid and ascending by freq. Slots >= count are don't-care.
- States: LOAD, MERGE, DONE. Reset -> LOAD, count=0, k=0.
- LOAD:
  - in_ready = 1 when count<6.
  - On accept, insert position p = number of valid slots with freq <= in_freq. This is stable: a tie lands after the existing entries.
  - Same cycle: slot p gets the new leaf; slot j in (p, count] gets slot j-1. q_wr_en is asserted for p..count only. count += 1.
  - Transition when the accepted leaf has in_last, or count reaches 6: go to MERGE if new count >= 2, else DONE.
  - in_valid with in_ready=0 is ignored.
- MERGE:
  - merge_valid = 1. left = slot0, right = slot1, merge_freq = sat(freq0 + freq1), saturating at 2^FREQ_W-1. merge_node_id = {1,k}.
  - On merge_valid && merge_ready, the pop and insert happen in one cycle. p = number of slots 2..count-1 with freq <= merge_freq. New slot j gets: slot j+2 if j<p; the new node if j==p; slot j+1 if p<j<count-1. count -= 1, k += 1.
  - When the new count == 1, go to DONE.
  - merge_ready low: hold all merge outputs stable, no queue writes.
- DONE:
  - done = 1; root_id and root_freq come from slot0.
  - clear -> LOAD; count and k reset to 0; done drops the next cycle. clear outside DONE is ignored.
- Reset mid-operation returns to LOAD immediately. The queue slots are cleared via the shared ctrl_reset. No merge event is emitted.

## Timing
- Reset values: in_ready=1 after ctrl_reset deasserts (0 while asserted). q_wr_en=0, merge_valid=0, done=0, merge_*/root_* = 0.
- q_wr_* are combinational from the state and the accept/merge handshake. Slots capture on the same clk edge, and the q_rd_* values are updated one cycle later.
- Insert throughput is 1 leaf/cycle. Merge throughput is 1 merge/cycle when merge_ready is held high.
- The MERGE entry cycle directly follows the last accept, since q_rd_* are already updated.
- done is asserted the cycle after the final merge handshake, or after the last accept when only one leaf was loaded.
- Sum uses FREQ_W+1 internal bits; bit FREQ_W set forces all-ones.

## Test plan
- Reset: hold ctrl_reset 3 cycles -> in_ready=0, q_wr_en=0, merge_valid=0, done=0. After release, in_ready=1.
- Load A:5, B:1, C:3 (last on C) -> slots B,C,A. Merge (0x042,0x043) freq 4 id 0x100, then (0x100,0x041) freq 9 id 0x101. done=1, root_id=0x101, root_freq=9.
- Ties: X:2, Y:2 -> slot order X,Y; merge left=0x058, right=0x059. Then insert Z:4 case: sum 4 is placed after existing Z:4.
- Six leaves 1..6, no in_last -> in_ready=0 after the 6th, five merges with k=0..4. merge_ready held low 3 cycles mid-run -> outputs stable, q_wr_en=0.
- Saturation: freqs 0xFFFFFFF0 and 0x20 -> merge_freq=0xFFFFFFFF.
- Single leaf Q:7 with in_last -> no merge_valid, done=1, root_id=0x051. Then clear -> in_ready=1. Separately, reset during MERGE -> LOAD, count=0, no spurious merge.
